nco_chan_sched: RTL

NCO_CHAN_SCHED -- requirements
Module: nco_chan_sched

---
 rtl/nco_chan_sched.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/nco_chan_sched.sv
// rtl/nco_chan_sched.sv - NCO channel-hopping scheduler: walks a table of enabled phase increments with a per-channel dwell.
// Build macro SCHED_LOOP_EN: repeat the sweep until stop instead of ending in DONE.
module nco_chan_sched #(
    parameter int N   = 32,
    parameter int CHW = 3,
    parameter int DW  = 24
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           wr_en,
    input  logic [CHW-1:0] wr_addr,
    input  logic [N-1:0]   wr_inc,
    input  logic           wr_ena,
    input  logic [DW-1:0]  dwell,
    input  logic           start,
    input  logic           stop,
    output logic [N-1:0]   phase_inc,
    output logic [CHW-1:0] chan_idx,
    output logic           hop,
    output logic           busy,
    output logic           done,
    output logic           err_none
);
    localparam int NE = 1 << CHW;

    typedef enum logic [1:0] {IDLE, SEEK, DWELL, DONE} state_t;

    state_t         state_q, state_d;
    logic [CHW-1:0] ptr_q, ptr_d;
    logic [CHW-1:0] scan_q, scan_d;
    logic [CHW-1:0] chan_idx_q, chan_idx_d;
    logic [DW-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic [N-1:0]   phase_inc_q, phase_inc_d;
    logic           hop_q, hop_d;
    logic           done_q, done_d;
    logic           err_none_q, err_none_d;
    logic [NE-1:0]  ena_q, ena_d;
    logic [N-1:0]   inc_q [NE];
    logic [N-1:0]   inc_d [NE];
    logic [DW-1:0]  dwell_load;
    logic           seek_finish;
    logic           dwell_finish;

    always_comb begin
        ena_d = ena_q;
        inc_d = inc_q;
        if (wr_en) begin
            ena_d[wr_addr] = wr_ena;
            inc_d[wr_addr] = wr_inc;
        end
    end

`ifdef SCHED_LOOP_EN
    assign seek_finish  = 1'b0;
    assign dwell_finish = 1'b0;
`else
    logic any_above;

    // Looking ahead lets a single pass end right after the last enabled channel.
    always_comb begin
        any_above = 1'b0;
        for (int i = 0; i < NE; i++) begin
            if (CHW'(i) > ptr_q && ena_q[i]) begin
                any_above = 1'b1;
            end
        end
    end

    assign seek_finish  = (ptr_q == '1);
    assign dwell_finish = ~any_above;
`endif

    assign dwell_load = (dwell == '0) ? DW'(1) : dwell;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        scan_d      = scan_q;
        chan_idx_d  = chan_idx_q;
        dwell_cnt_d = dwell_cnt_q;
        phase_inc_d = phase_inc_q;
        hop_d       = 1'b0;
        done_d      = 1'b0;
        err_none_d  = 1'b0;
        if (stop) begin
            state_d     = IDLE;
            phase_inc_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = SEEK;
                        ptr_d   = '0;
                        scan_d  = '0;
                    end
                end
                SEEK: begin
                    if (ena_q[ptr_q]) begin
                        state_d     = DWELL;
                        phase_inc_d = inc_q[ptr_q];
                        chan_idx_d  = ptr_q;
                        hop_d       = 1'b1;
                        dwell_cnt_d = dwell_load;
                    end else if (scan_q == '1) begin
                        state_d     = IDLE;
                        err_none_d  = 1'b1;
                        phase_inc_d = '0;
                    end else if (seek_finish) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        phase_inc_d = '0;
                    end else begin
                        ptr_d  = ptr_q + 1'b1;
                        scan_d = scan_q + 1'b1;
                    end
                end
                DWELL: begin
                    if (dwell_cnt_q <= DW'(1)) begin
                        ptr_d  = ptr_q + 1'b1;
                        scan_d = '0;
                        if (dwell_finish) begin
                            state_d     = DONE;
                            done_d      = 1'b1;
                            phase_inc_d = '0;
                        end else begin
                            state_d = SEEK;
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q - 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            scan_q      <= '0;
            chan_idx_q  <= '0;
            dwell_cnt_q <= '0;
            phase_inc_q <= '0;
            hop_q       <= 1'b0;
            done_q      <= 1'b0;
            err_none_q  <= 1'b0;
            ena_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            scan_q      <= scan_d;
            chan_idx_q  <= chan_idx_d;
            dwell_cnt_q <= dwell_cnt_d;
            phase_inc_q <= phase_inc_d;
            hop_q       <= hop_d;
            done_q      <= done_d;
            err_none_q  <= err_none_d;
            ena_q       <= ena_d;
        end
    end

    // Increments survive reset; only the enable bits are cleared.
    always_ff @(posedge clk) begin
        inc_q <= inc_d;
    end

    assign phase_inc = phase_inc_q;
    assign chan_idx  = chan_idx_q;
    assign hop       = hop_q;
    assign done      = done_q;
    assign err_none  = err_none_q;
    assign busy      = (state_q == SEEK) || (state_q == DWELL);

endmodule
